// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: LANES signed dot products over a streamed job,
// followed by saturation and optional ReLU, with the result held under valid/ready.
module fc_mac_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned LANES  = 3,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 19,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        vec1,
  input  logic [LANES*WGT_W-1:0]   vec2,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [LANES*OUT_W-1:0]   o,
  output logic                     busy
);

  localparam int unsigned PROD_W = DATA_W + WGT_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic                    relu_q, relu_d;
  logic [LANES*OUT_W-1:0]  o_q, o_d, o_sat;
  logic signed [ACC_W-1:0] acc_q   [LANES];
  logic signed [ACC_W-1:0] acc_d   [LANES];
  logic signed [ACC_W-1:0] acc_sum [LANES];
  logic signed [ACC_W-1:0] sat     [LANES];
  logic signed [PROD_W-1:0] prod   [LANES];
  logic                    beat, last_beat;

  assign beat      = (state_q == StAcc) && in_valid;
  assign last_beat = beat && (count_q == len_q - LEN_W'(1));

  // Full-precision product, sign-extended into the wrapping accumulator.
  always_comb begin : p_dot
    for (int i = 0; i < LANES; i++) begin
      prod[i]    = $signed(vec1) * $signed(vec2[i*WGT_W +: WGT_W]);
      acc_sum[i] = acc_q[i] + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end
  end

  // Clamp first, then ReLU, so a clamped negative still becomes zero.
  always_comb begin : p_sat
    o_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      if (acc_sum[i] > SAT_MAX) begin
        sat[i] = SAT_MAX;
      end else if (acc_sum[i] < SAT_MIN) begin
        sat[i] = SAT_MIN;
      end else begin
        sat[i] = acc_sum[i];
      end
      if (relu_q && sat[i][ACC_W-1]) begin
        sat[i] = '0;
      end
      o_sat[i*OUT_W +: OUT_W] = sat[i][OUT_W-1:0];
    end
  end

  always_comb begin : p_fsm
    state_d = state_q;
    len_d   = len_q;
    relu_d  = relu_q;
    count_d = count_q;
    o_d     = o_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          relu_d  = relu_en;
          count_d = '0;
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = '0;
          end
          if (len == '0) begin
            o_d     = '0;
            state_d = StHold;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d   = acc_sum;
          count_d = count_q + LEN_W'(1);
          if (last_beat) begin
            o_d     = o_sat;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (o_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      relu_q  <= 1'b0;
      count_q <= '0;
      o_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
      count_q <= count_d;
      o_q     <= o_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready = (state_q == StAcc);
  assign o_valid  = (state_q == StHold);
  assign busy     = (state_q != StIdle);
  assign o        = o_q;

endmodule

// File: tb/tb_fc_mac_engine.sv
// Bench for fc_mac_engine: directed jobs plus randomized jobs against a plain
// arithmetic dot-product model; a monitor compares o whenever o_valid is high.
module tb_fc_mac_engine;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int NL = 3;
  localparam int OUTW = 19;
  localparam int LW = 10;
  localparam int OW = NL * OUTW;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [LW-1:0]  len;
  logic           relu_en;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  vec1;
  logic [NL*WW-1:0] vec2;
  logic           o_valid;
  logic           o_ready;
  logic [OW-1:0]  o;
  logic           busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_o = '0;
  bit exp_live = 1'b0;

  int xs [1024];
  int ws [1024][NL];
  bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  fc_mac_engine #(
    .DATA_W(DW), .WGT_W(WW), .LANES(NL), .ACC_W(32), .OUT_W(OUTW), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .vec1(vec1), .vec2(vec2),
    .o_valid(o_valid), .o_ready(o_ready), .o(o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack3(input int a, input int b, input int c);
    logic [OW-1:0] r;
    r = '0;
    r[0 +: OUTW]      = OUTW'(a);
    r[OUTW +: OUTW]   = OUTW'(b);
    r[2*OUTW +: OUTW] = OUTW'(c);
    return r;
  endfunction

  function automatic logic [NL*WW-1:0] pack_w(input int k);
    logic [NL*WW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*WW +: WW] = WW'(ws[k][i]);
    return r;
  endfunction

  // Reference: integer dot product, 32-bit wrap, clamp to OUTW signed, then ReLU.
  function automatic logic [OW-1:0] model_result(input int n, input bit relu);
    logic [OW-1:0] r;
    longint s;
    longint hi, lo;
    hi = (longint'(1) <<< (OUTW - 1)) - 1;
    lo = -(longint'(1) <<< (OUTW - 1));
    r = '0;
    for (int lane = 0; lane < NL; lane++) begin
      s = 0;
      for (int k = 0; k < n; k++) s += longint'(xs[k]) * longint'(ws[k][lane]);
      s = longint'(int'(s));
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (relu && s < 0) s = 0;
      r[lane*OUTW +: OUTW] = OUTW'(s);
    end
    return r;
  endfunction

  task automatic set_beat(input int k, input int x, input int a, input int b, input int c);
    xs[k] = x; ws[k][0] = a; ws[k][1] = b; ws[k][2] = c;
  endtask

  // mode: 0 = in_valid always high, 1 = fixed gap pattern, 2 = random gaps
  task automatic run_job(input int n, input bit relu, input int mode, input int hold,
                         input bit poke_start, output logic [OW-1:0] got);
    int k, guard, step;
    bit v, fire;
    logic [OW-1:0] e;
    e = model_result(n, relu);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    // A beat presented alongside start must not be taken.
    start = 1; len = LW'(n); relu_en = relu;
    in_valid = 1; vec1 = DW'(xs[0]); vec2 = pack_w(0);
    @(negedge clk);
    start = 0; in_valid = 0;
    if (n == 0) begin
      exp_o = e; exp_live = 1;
    end else begin
      check("acc_in_ready", in_ready, 1);
      check("acc_busy", busy, 1);
      k = 0; guard = 0; step = 0;
      while (k < n && guard < 20000) begin
        if (mode == 0) v = 1;
        else if (mode == 1) v = pat[step % 7];
        else v = ($urandom_range(0, 9) < 7);
        in_valid = v; vec1 = DW'(xs[k]); vec2 = pack_w(k);
        fire = v && in_ready;
        @(negedge clk);
        guard++; step++;
        if (fire) k++;
      end
      if (k < n) check("beat_budget", 64'(k), 64'(n));
      in_valid = 0;
      exp_o = e; exp_live = 1;
    end
    check("o_valid_latency", o_valid, 1);
    got = o;
    for (int h = 0; h < hold; h++) begin
      if (poke_start) begin start = 1; len = 5; end
      @(negedge clk);
      start = 0;
      check("hold_o_valid", o_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_in_ready", in_ready, 0);
    end
    o_ready = 1;
    @(negedge clk);
    o_ready = 0; exp_live = 0;
    check("post_hs_busy", busy, 0);
    check("post_hs_o_valid", o_valid, 0);
  endtask

  // Monitor: o_valid only when a result is due, and o then matches the model.
  always begin
    @(negedge clk);
    #2;
    if (o_valid) begin
      if (!exp_live) check("unexpected_o_valid", o_valid, 0);
      else check("o_vs_model", o, exp_o);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] got;
    reset = 1; start = 0; len = 0; relu_en = 0; in_valid = 0;
    vec1 = 0; vec2 = 0; o_ready = 0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_o", o, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) set_beat(k, k + 1, 1, -1, 2);
    run_job(4, 0, 0, 1, 0, got);
    check("s1_lanes", got, pack3(10, -10, 20));

    run_job(4, 1, 0, 0, 0, got);
    check("s2_relu_lanes", got, pack3(10, 0, 20));

    for (int k = 0; k < 1023; k++) set_beat(k, 127, 127, -128, 0);
    run_job(1023, 0, 0, 1, 0, got);
    check("s3_sat_lanes", got, pack3(262143, -262144, 0));

    for (int k = 0; k < 4; k++) set_beat(k, k + 1, 1, -1, 2);
    run_job(4, 0, 1, 0, 0, got);
    check("s4_gap_lanes", got, pack3(10, -10, 20));

    run_job(4, 0, 0, 6, 1, got);
    check("s5_hold_lanes", got, pack3(10, -10, 20));

    // Reset after two of four beats.
    start = 1; len = 4; relu_en = 0;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; vec1 = DW'(xs[k]); vec2 = pack_w(k);
      @(negedge clk);
    end
    in_valid = 0;
    reset = 1;
    #1;
    check("s6_rst_in_ready", in_ready, 0);
    check("s6_rst_o_valid", o_valid, 0);
    check("s6_rst_busy", busy, 0);
    @(negedge clk);
    check("s6_rst_busy_held", busy, 0);
    reset = 0;
    @(negedge clk);
    run_job(4, 0, 0, 0, 0, got);
    check("s6_fresh_lanes", got, pack3(10, -10, 20));

    run_job(0, 0, 0, 1, 0, got);
    check("len0_lanes", got, 0);

    for (int r = 0; r < 24; r++) begin
      int n;
      bit relu;
      if (r == 7) n = 0;
      else if (r % 5 == 0) n = $urandom_range(100, 400);
      else n = $urandom_range(1, 20);
      relu = $urandom_range(0, 1);
      for (int k = 0; k < n; k++) begin
        set_beat(k, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      end
      run_job(n, relu, 2, $urandom_range(0, 3), r[0], got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
